// File: rtl/morse_key_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// morse_key_pkg : shared constants, key indices and per-key state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package morse_key_pkg;

  localparam int NUM_KEYS_DEF   = 12;
  localparam int TICK_DIV_DEF   = 50_000;
  localparam int DEB_TICKS_DEF  = 20;
  localparam int LONG_TICKS_DEF = 800;

  localparam int KEY_1  = 0;
  localparam int KEY_2  = 1;
  localparam int KEY_3  = 2;
  localparam int KEY_4  = 3;
  localparam int KEY_5  = 4;
  localparam int KEY_6  = 5;
  localparam int KEY_7  = 6;
  localparam int KEY_8  = 7;
  localparam int KEY_9  = 8;
  localparam int KEY_10 = 9;
  localparam int KEY_11 = 10;
  localparam int KEY_12 = 11;

  typedef enum logic [0:0] {
    KEY_RELEASED = 1'b0,
    KEY_PRESSED  = 1'b1
  } key_state_t;

  // One spare bit above $clog2 so a counter can hold its own maximum value.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/morse_key_debouncer_if.sv
// ---------------------------------------------------------------------------
// morse_key_debouncer_if : raw key inputs and conditioned key outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface morse_key_debouncer_if
  import morse_key_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEF
);

  logic [NUM_KEYS-1:0] btn_raw;
  logic [NUM_KEYS-1:0] btn_level;
  logic [NUM_KEYS-1:0] btn_press;
  logic [NUM_KEYS-1:0] btn_release;
  logic [NUM_KEYS-1:0] btn_long;
  logic                any_pressed;
  logic                tick;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_long, any_pressed, tick
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_long, any_pressed, tick
  );

endinterface

`default_nettype wire

// File: rtl/morse_key_debouncer_cell.sv
// ---------------------------------------------------------------------------
// morse_key_debounce_cell : one key - synchroniser, debounce FSM, hold timer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module morse_key_debounce_cell
  import morse_key_pkg::*;
#(
  parameter int DEB_TICKS  = DEB_TICKS_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int                 DB_W      = cnt_width(DEB_TICKS);
  localparam int                 HOLD_W    = cnt_width(LONG_TICKS);
  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEB_TICKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

  logic [1:0]        sync;
  key_state_t        state;
  logic [DB_W-1:0]   db;
  logic [HOLD_W-1:0] hold;
  logic              sampled;
  logic              mismatch;
  logic              accept;
  logic              releasing;

  always_comb begin
    sampled   = (ACTIVE_LOW != 0) ? ~sync[1] : sync[1];
    mismatch  = sampled != (state == KEY_PRESSED);
    accept    = mismatch && tick && (db == DB_LAST);
    releasing = accept && (state == KEY_PRESSED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync          <= '0;
      state         <= KEY_RELEASED;
      db            <= '0;
      hold          <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      sync <= {sync[0], raw};

      // Outputs trail the accepted state by one cycle so level and pulse align.
      level         <= (state == KEY_PRESSED);
      press_pulse   <= (state == KEY_PRESSED) && !level;
      release_pulse <= (state == KEY_RELEASED) && level;
      long_pulse    <= 1'b0;

      if (!mismatch) begin
        db <= '0;
      end else if (tick) begin
        if (accept) begin
          db    <= '0;
          state <= (state == KEY_PRESSED) ? KEY_RELEASED : KEY_PRESSED;
        end else begin
          db <= db + DB_W'(1);
        end
      end

      // A release accepted on the same tick wins over the long-press pulse.
      if (state == KEY_RELEASED || releasing) begin
        hold <= '0;
      end else if (tick && hold != HOLD_MAX) begin
        hold       <= hold + HOLD_W'(1);
        long_pulse <= (hold == HOLD_LAST);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/morse_key_debouncer.sv
// ---------------------------------------------------------------------------
// morse_key_debouncer : shared tick prescaler plus one debounce cell per key
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module morse_key_debouncer
  import morse_key_pkg::*;
#(
  parameter int NUM_KEYS   = NUM_KEYS_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEB_TICKS  = DEB_TICKS_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  morse_key_debouncer_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]    cnt_t;
  logic                tick_q;
  logic [NUM_KEYS-1:0] level_vec;
  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] release_vec;
  logic [NUM_KEYS-1:0] long_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_t  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_t == CNT_LAST);
      cnt_t  <= (cnt_t == CNT_LAST) ? '0 : cnt_t + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    morse_key_debounce_cell #(
      .DEB_TICKS  (DEB_TICKS),
      .LONG_TICKS (LONG_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_cell (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick_q),
      .raw           (bus.btn_raw[k]),
      .level         (level_vec[k]),
      .press_pulse   (press_vec[k]),
      .release_pulse (release_vec[k]),
      .long_pulse    (long_vec[k])
    );
  end

  assign bus.btn_level   = level_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;
  assign bus.btn_long    = long_vec;
  assign bus.any_pressed = |level_vec;
  assign bus.tick        = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_morse_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_morse_key_debouncer : directed scenarios plus random key activity,
// every cycle compared against a tick-counting reference model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_morse_key_debouncer;
  import morse_key_pkg::*;

  localparam int NK   = 12;
  localparam int TD   = 4;
  localparam int DEB  = 3;
  localparam int LONG = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  morse_key_debouncer_if #(.NUM_KEYS(NK)) bus ();

  morse_key_debouncer #(
    .NUM_KEYS   (NK),
    .TICK_DIV   (TD),
    .DEB_TICKS  (DEB),
    .LONG_TICKS (LONG),
    .ACTIVE_LOW (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: cycle n counts clock edges since reset release, ticks
  // fall on multiples of TD, and a key flips once DEB ticks have elapsed
  // since its synchronised input last agreed with the accepted level.
  int              n;
  logic [NK-1:0]   r1, mst;
  logic [NK-1:0]   lvl_c, prs_c, rel_c, lng_c, lvl_n, prs_n, rel_n;
  int              last_agree [NK];
  int              press_at   [NK];
  int              press_cnt  [NK];
  int              rel_cnt    [NK];
  int              long_cnt   [NK];
  int              press_stamp[NK];
  int              long_stamp [NK];
  int              tick_total = 0;

  always @(posedge clk) begin
    logic [NK-1:0] s, new_prs, new_rel, new_lng;
    logic          tick_exp, was, rel_now;
    #1;
    for (int k = 0; k < NK; k++) begin
      if (bus.btn_press[k])   begin press_cnt[k]++; press_stamp[k] = tick_total; end
      if (bus.btn_release[k]) rel_cnt[k]++;
      if (bus.btn_long[k])    begin long_cnt[k]++;  long_stamp[k]  = tick_total; end
    end
    if (bus.tick) tick_total++;

    if (rst) begin
      chk("rst_level",  32'(bus.btn_level), 0);
      chk("rst_pulses", 32'(bus.btn_press | bus.btn_release | bus.btn_long), 0);
      chk("rst_misc",   32'({bus.any_pressed, bus.tick}), 0);
      n = 0; r1 = '0; mst = '0;
      lvl_c = '0; prs_c = '0; rel_c = '0; lng_c = '0;
      lvl_n = '0; prs_n = '0; rel_n = '0;
      for (int k = 0; k < NK; k++) begin last_agree[k] = 0; press_at[k] = 0; end
    end else begin
      n++;
      tick_exp = (n % TD == 0);
      chk("tick",        32'(bus.tick),        32'(tick_exp));
      chk("level",       32'(bus.btn_level),   32'(lvl_c));
      chk("press",       32'(bus.btn_press),   32'(prs_c));
      chk("release",     32'(bus.btn_release), 32'(rel_c));
      chk("long",        32'(bus.btn_long),    32'(lng_c));
      chk("any_pressed", 32'(bus.any_pressed), 32'(|lvl_c));
      s  = r1;
      r1 = bus.btn_raw;
      new_prs = '0; new_rel = '0; new_lng = '0;
      for (int k = 0; k < NK; k++) begin
        was = mst[k]; rel_now = 1'b0;
        if (s[k] == mst[k]) begin
          last_agree[k] = n;
        end else if (tick_exp && (n / TD - last_agree[k] / TD) >= DEB) begin
          mst[k] = ~mst[k];
          last_agree[k] = n;
          if (mst[k]) begin new_prs[k] = 1'b1; press_at[k] = n; end
          else begin new_rel[k] = 1'b1; rel_now = 1'b1; end
        end
        if (tick_exp && was && !rel_now && (n - press_at[k]) == LONG * TD) new_lng[k] = 1'b1;
      end
      lvl_c = lvl_n; prs_c = prs_n; rel_c = rel_n; lng_c = new_lng;
      lvl_n = mst;   prs_n = new_prs; rel_n = new_rel;
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NK; k++) begin press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0; end
  endtask

  // kind: 0 press, 1 release, 2 long; lat = cycles until seen, -1 on timeout
  task automatic wait_pulse(input int key, input int kind, output int lat);
    logic hit;
    lat = 0; hit = 1'b0;
    while (!hit && lat < 60) begin
      @(posedge clk); #1; lat++;
      case (kind)
        0:       hit = bus.btn_press[key];
        1:       hit = bus.btn_release[key];
        default: hit = bus.btn_long[key];
      endcase
    end
    if (!hit) lat = -1;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    bus.btn_raw = '0;
    clear_counts();
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Clean press then release of key 1
    bus.btn_raw[KEY_1] = 1'b1;
    wait_pulse(KEY_1, 0, lat);
    chk("s1_press_latency_ok", 32'(lat >= 11 && lat <= 15), 1);
    chk("s1_level", 32'(bus.btn_level[KEY_1]), 1);
    chk("s1_any", 32'(bus.any_pressed), 1);
    bus.btn_raw[KEY_1] = 1'b0;
    wait_pulse(KEY_1, 1, lat);
    chk("s3_release_latency_ok", 32'(lat >= 11 && lat <= 15), 1);
    chk("s3_level", 32'(bus.btn_level[KEY_1]), 0);
    cycles(20);
    chk("s3_press_once", 32'(press_cnt[KEY_1]), 1);
    chk("s3_release_once", 32'(rel_cnt[KEY_1]), 1);
    chk("s3_no_long", 32'(long_cnt[KEY_1]), 0);

    // Bounce on key 4
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      bus.btn_raw[KEY_4] = ~bus.btn_raw[KEY_4];
      cycles(5);
    end
    cycles(30);
    chk("s2_no_events", 32'(press_cnt[KEY_4] + rel_cnt[KEY_4] + long_cnt[KEY_4]), 0);
    chk("s2_level", 32'(bus.btn_level[KEY_4]), 0);

    // Long press on key 6
    clear_counts();
    bus.btn_raw[KEY_6] = 1'b1;
    wait_pulse(KEY_6, 0, lat);
    chk("s4_press_seen", 32'(lat > 0), 1);
    wait_pulse(KEY_6, 2, lat);
    chk("s4_long_seen", 32'(lat > 0), 1);
    chk("s4_ticks_press_to_long", 32'(long_stamp[KEY_6] - press_stamp[KEY_6]), LONG);
    cycles(60);
    chk("s4_press_once", 32'(press_cnt[KEY_6]), 1);
    chk("s4_long_once", 32'(long_cnt[KEY_6]), 1);
    bus.btn_raw[KEY_6] = 1'b0;
    cycles(25);

    // Simultaneous keys 2 and 12
    bus.btn_raw[KEY_2]  = 1'b1;
    bus.btn_raw[KEY_12] = 1'b1;
    wait_pulse(KEY_2, 0, lat);
    chk("s5_press_other_same_cycle", 32'(bus.btn_press[KEY_12]), 1);
    chk("s5_level", 32'(bus.btn_level), 32'h802);
    bus.btn_raw[KEY_2]  = 1'b0;
    bus.btn_raw[KEY_12] = 1'b0;
    cycles(25);

    // Reset in the middle of debouncing key 3
    bus.btn_raw[KEY_3] = 1'b1;
    cycles(6);
    rst = 1'b1;
    cycles(1);
    chk("s6_level_in_reset", 32'(bus.btn_level), 0);
    cycles(2);
    rst = 1'b0;
    wait_pulse(KEY_3, 0, lat);
    chk("s6_press_after_reset_ok", 32'(lat >= 11 && lat <= 15), 1);
    bus.btn_raw[KEY_3] = 1'b0;
    cycles(25);

    // Random activity on all keys, with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        k = int'($urandom_range(0, NK - 1));
        bus.btn_raw[k] = ~bus.btn_raw[k];
      end
      if (c == 1700) rst = 1'b1;
      if (c == 1703) rst = 1'b0;
      cycles(1);
    end
    bus.btn_raw = '0;
    cycles(60);
    chk("end_level", 32'(bus.btn_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
